// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point converter.
//   bfp_slice_w : width of one packed {exponent, mantissa} input lane
//   bfp_log2    : ceil(log2(n)), used to size the max-exponent tree
package bfp_pkg;

    function automatic int bfp_slice_w(input int exp_w, input int mant_w);
        return exp_w + mant_w;
    endfunction

    function automatic int bfp_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bfp_lane_align.sv
// Per-lane mantissa alignment: shifts one mantissa right by its distance d
// from the block exponent in a single step.
//   mantissa : unsigned mantissa magnitude of the lane
//   d        : block exponent minus lane exponent (never negative)
//   aligned  : aligned mantissa
// Build option BFP_CONVERTER_ROUND_EN: when defined, the shifted-out bits are
// rounded to nearest, ties to even; otherwise they are truncated.
module bfp_lane_align #(
    parameter int MANTISSA_WIDTH = 7,
    parameter int EXPONENT_WIDTH = 8
) (
    input  logic [MANTISSA_WIDTH-1:0] mantissa,
    input  logic [EXPONENT_WIDTH-1:0] d,
    output logic [MANTISSA_WIDTH-1:0] aligned
);

    // Shift distance compared one bit wider so MANTISSA_WIDTH always fits.
    localparam logic [EXPONENT_WIDTH:0] MW_X = (EXPONENT_WIDTH + 1)'(MANTISSA_WIDTH);

    function automatic logic [MANTISSA_WIDTH-1:0] round_shift(
        input logic [MANTISSA_WIDTH-1:0] m,
        input logic [EXPONENT_WIDTH-1:0] sh
    );
`ifdef BFP_CONVERTER_ROUND_EN
        logic [MANTISSA_WIDTH-1:0] kept;
        logic [MANTISSA_WIDTH-1:0] frac;
        logic [MANTISSA_WIDTH-1:0] half;
        int amt;
        if ({1'b0, sh} > MW_X) return '0;
        amt = int'(sh);
        if (amt == 0) return m;
        kept = m >> amt;
        frac = m & MANTISSA_WIDTH'((1 << amt) - 1);
        half = MANTISSA_WIDTH'(1 << (amt - 1));
        // kept is at most m >> 1 here, so the increment cannot overflow.
        if ((frac > half) || ((frac == half) && kept[0])) begin
            kept = kept + MANTISSA_WIDTH'(1);
        end
        return kept;
`else
        if ({1'b0, sh} >= MW_X) return '0;
        return m >> sh;
`endif
    endfunction

    assign aligned = round_shift(mantissa, d);

endmodule

// File: rtl/bfp_block_converter.sv
// Converts a block of LANES floating-point values ({exponent, mantissa} per
// lane) into block floating point: one shared exponent (the block maximum)
// and per-lane mantissas right-aligned to it.
//   clk, rst         : clock, synchronous active-high reset
//   valid_i/ready_o  : input block handshake; data_i lane k at [(k+1)*W-1:k*W]
//   valid_o/ready_i  : output block handshake
//   mant_o           : aligned mantissas, lane k at [(k+1)*MW-1:k*MW]
//   exp_o            : shared block exponent
// Pipeline: input register, log2(LANES) pairwise-max stages, align/output
// stage. A single enable stalls the whole pipeline when the output is held.
// Build option BFP_CONVERTER_ROUND_EN selects lane rounding (see bfp_lane_align).
module bfp_block_converter
    import bfp_pkg::*;
#(
    parameter int LANES          = 32,
    parameter int MANTISSA_WIDTH = 7,
    parameter int EXPONENT_WIDTH = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           valid_i,
    output logic                                           ready_o,
    input  logic [LANES*(EXPONENT_WIDTH+MANTISSA_WIDTH)-1:0] data_i,
    output logic                                           valid_o,
    input  logic                                           ready_i,
    output logic [LANES*MANTISSA_WIDTH-1:0]                mant_o,
    output logic [EXPONENT_WIDTH-1:0]                      exp_o
);

    localparam int W    = bfp_slice_w(EXPONENT_WIDTH, MANTISSA_WIDTH);
    localparam int TREE = bfp_log2(LANES);

    logic                            en;
    logic                            vld_p  [TREE+1];
    logic [LANES*W-1:0]              data_p [TREE+1];
    logic [EXPONENT_WIDTH-1:0]       emax_p [TREE+1][LANES];
    logic [LANES*MANTISSA_WIDTH-1:0] aligned;

    function automatic logic [EXPONENT_WIDTH-1:0] max2(
        input logic [EXPONENT_WIDTH-1:0] a,
        input logic [EXPONENT_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign en      = ready_i || !valid_o;
    assign ready_o = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= TREE; s++) vld_p[s] <= 1'b0;
        end else if (en) begin
            vld_p[0] <= valid_i;
            for (int s = 1; s <= TREE; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    // Stage p0: input register; partial maxima start as the lane exponents.
    // Stages 1..TREE: stage s halves the live maxima (entries below
    // LANES >> s); entries above are simply carried and never consumed.
    // Lane data rides along unmodified for the align stage.
    always_ff @(posedge clk) begin
        if (en) begin
            data_p[0] <= data_i;
            for (int i = 0; i < LANES; i++) begin
                emax_p[0][i] <= data_i[i*W + MANTISSA_WIDTH +: EXPONENT_WIDTH];
            end
            for (int s = 1; s <= TREE; s++) begin
                data_p[s] <= data_p[s-1];
                for (int i = 0; i < LANES; i++) begin
                    if (i < (LANES >> s)) begin
                        emax_p[s][i] <= max2(emax_p[s-1][(2*i) & (LANES-1)],
                                             emax_p[s-1][((2*i) & (LANES-1)) | 1]);
                    end else begin
                        emax_p[s][i] <= emax_p[s-1][i];
                    end
                end
            end
        end
    end

    // Align stage: every lane's distance to the block maximum.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [EXPONENT_WIDTH-1:0] d;
        assign d = emax_p[TREE][0] - data_p[TREE][k*W + MANTISSA_WIDTH +: EXPONENT_WIDTH];

        bfp_lane_align #(
            .MANTISSA_WIDTH(MANTISSA_WIDTH),
            .EXPONENT_WIDTH(EXPONENT_WIDTH)
        ) u_align (
            .mantissa(data_p[TREE][k*W +: MANTISSA_WIDTH]),
            .d       (d),
            .aligned (aligned[k*MANTISSA_WIDTH +: MANTISSA_WIDTH])
        );
    end

    // Output stage: cleared on reset so a stale block can never surface.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            mant_o  <= '0;
            exp_o   <= '0;
        end else if (en) begin
            valid_o <= vld_p[TREE];
            mant_o  <= aligned;
            exp_o   <= emax_p[TREE][0];
        end
    end

endmodule

// File: tb/tb_bfp_block_converter.sv
// Directed bench for bfp_block_converter with LANES=4, MANTISSA_WIDTH=7,
// EXPONENT_WIDTH=8. Expected values are hand-computed; rounding-dependent
// ones follow BFP_CONVERTER_ROUND_EN.
module tb_bfp_block_converter;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [59:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [27:0] mant_o;
    logic [7:0]  exp_o;

    int n_chk;
    int n_fail;

    logic [59:0] sd [8];
    logic [7:0]  se [8];
    logic [27:0] sm [8];

    bfp_block_converter #(
        .LANES(4),
        .MANTISSA_WIDTH(7),
        .EXPONENT_WIDTH(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .mant_o (mant_o),
        .exp_o  (exp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [59:0] pk(
        input logic [7:0] e0, input logic [6:0] m0,
        input logic [7:0] e1, input logic [6:0] m1,
        input logic [7:0] e2, input logic [6:0] m2,
        input logic [7:0] e3, input logic [6:0] m3
    );
        return {e3, m3, e2, m2, e1, m1, e0, m0};
    endfunction

    function automatic logic [27:0] mk(
        input logic [6:0] l0, input logic [6:0] l1,
        input logic [6:0] l2, input logic [6:0] l3
    );
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one block, then check latency and the result.
    task automatic single(input logic [59:0] din, input logic [7:0] ee,
                          input logic [27:0] em, input string tag);
        int lat;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = din;
        chk({tag, "_ready"}, 64'(ready_o), 64'(1));
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 12) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(4));
        chk({tag, "_exp"}, 64'(exp_o), 64'(ee));
        chk({tag, "_mant"}, 64'(mant_o), 64'(em));
    endtask

    initial begin
        int tx;
        int rx;
        logic held;
        logic [7:0]  snap_e;
        logic [27:0] snap_m;

        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;

        for (int b = 0; b < 8; b++) begin
            sd[b] = pk(8'(b + 5), 7'(8'h10 + b), 8'(b + 5), 7'(8'h18 + b),
                       8'(b + 4), 7'(8'h20 + 4 * b), 8'(b + 3), 7'(8'h40 + 4 * b));
            se[b] = 8'(b + 5);
            sm[b] = mk(7'(8'h10 + b), 7'(8'h18 + b), 7'(8'h10 + 2 * b), 7'(8'h10 + b));
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_exp_o", 64'(exp_o), 64'(0));
        chk("rst_mant_o", 64'(mant_o), 64'(0));
        chk("rst_ready_o", 64'(ready_o), 64'(1));
        ready_i = 1'b0;
        #1;
        chk("idle_ready_no_ready_i", 64'(ready_o), 64'(1));
        ready_i = 1'b1;

        // Directed blocks
`ifdef BFP_CONVERTER_ROUND_EN
        single(pk(10, 7'h40, 12, 7'h7F, 12, 7'h01, 8, 7'h7F), 8'd12,
               mk(7'h10, 7'h7F, 7'h01, 7'h08), "basic");
        single(pk(10, 7'h05, 10, 7'h07, 11, 7'h33, 4, 7'h7F), 8'd11,
               mk(7'h02, 7'h04, 7'h33, 7'h01), "ties_a");
        single(pk(1, 7'h11, 2, 7'h22, 3, 7'h33, 9, 7'h44), 8'd9,
               mk(7'h00, 7'h00, 7'h01, 7'h44), "max_lane3");
`else
        single(pk(10, 7'h40, 12, 7'h7F, 12, 7'h01, 8, 7'h7F), 8'd12,
               mk(7'h10, 7'h7F, 7'h01, 7'h07), "basic");
        single(pk(10, 7'h05, 10, 7'h07, 11, 7'h33, 4, 7'h7F), 8'd11,
               mk(7'h02, 7'h03, 7'h33, 7'h00), "ties_a");
        single(pk(1, 7'h11, 2, 7'h22, 3, 7'h33, 9, 7'h44), 8'd9,
               mk(7'h00, 7'h00, 7'h00, 7'h44), "max_lane3");
`endif
        single(pk(4, 7'h40, 11, 7'h2A, 3, 7'h7F, 0, 7'h7F), 8'd11,
               mk(7'h00, 7'h2A, 7'h00, 7'h00), "ties_b");
        single(pk(20, 7'h7F, 3, 7'h7F, 3, 7'h7F, 3, 7'h7F), 8'd20,
               mk(7'h7F, 7'h00, 7'h00, 7'h00), "large_gap");
        single(pk(0, 7'h12, 0, 7'h34, 0, 7'h56, 0, 7'h78), 8'd0,
               mk(7'h12, 7'h34, 7'h56, 7'h78), "all_zero_exp");

        // Streaming: 8 back-to-back blocks
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            if (t >= 4 && t < 12) begin
                chk("stream_valid", 64'(valid_o), 64'(1));
                chk("stream_exp", 64'(exp_o), 64'(se[t-4]));
                chk("stream_mant", 64'(mant_o), 64'(sm[t-4]));
            end else begin
                chk("stream_idle", 64'(valid_o), 64'(0));
            end
            if (t < 8) begin
                valid_i = 1'b1;
                data_i  = sd[t];
                chk("stream_ready", 64'(ready_o), 64'(1));
            end else begin
                valid_i = 1'b0;
            end
        end

        // Backpressure: ready_i low for 5 cycles mid-stream
        tx   = 0;
        rx   = 0;
        held = 1'b0;
        snap_e = '0;
        snap_m = '0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            ready_i = !(t >= 6 && t < 11);
            #1;
            if (valid_o) begin
                if (held) begin
                    chk("bp_hold_exp", 64'(exp_o), 64'(snap_e));
                    chk("bp_hold_mant", 64'(mant_o), 64'(snap_m));
                end
                if (!ready_i) begin
                    chk("bp_ready_low", 64'(ready_o), 64'(0));
                    snap_e = exp_o;
                    snap_m = mant_o;
                    held   = 1'b1;
                end else begin
                    held = 1'b0;
                    chk("bp_no_extra", 64'(rx < 8), 64'(1));
                    chk("bp_exp", 64'(exp_o), 64'(se[rx & 7]));
                    chk("bp_mant", 64'(mant_o), 64'(sm[rx & 7]));
                    rx++;
                end
            end else begin
                held = 1'b0;
            end
            if (tx < 8) begin
                valid_i = 1'b1;
                data_i  = sd[tx];
                if (ready_o) tx++;
            end else begin
                valid_i = 1'b0;
            end
        end
        chk("bp_received", 64'(rx), 64'(8));
        chk("bp_sent", 64'(tx), 64'(8));

        // Reset with 3 blocks in flight
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = sd[t];
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid_o", 64'(valid_o), 64'(0));
        chk("midrst_ready_o", 64'(ready_o), 64'(1));
        chk("midrst_exp_o", 64'(exp_o), 64'(0));
        chk("midrst_mant_o", 64'(mant_o), 64'(0));
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("midrst_no_stale", 64'(valid_o), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
